// File: rtl/rv32v_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : rv32v_addr_gen
// Purpose  : Vector load/store address generator. It splits a request into
//            beats of NUM_LANES elements and screens each beat for misaligned
//            elements. Defining RV32V_STRIDED_EN adds strided addressing.
// Revision : 1.0 - initial release
// ============================================================================
module rv32v_addr_gen #(
    parameter int NUM_LANES = 4,
    parameter int VLMAX     = 32
) (
    input  logic                              CLK,
    input  logic                              nRST,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_store,
    input  logic [31:0]                       base,
    input  logic [31:0]                       stride,
    input  logic                              strided,
    input  logic [1:0]                        eew,
    input  logic [$clog2(VLMAX):0]            vl,
    input  logic                              vm,
    input  logic [VLMAX-1:0]                  vmask,
    input  logic                              lsc_ready,
    output logic                              wen,
    output logic                              ren,
    output logic [NUM_LANES-1:0][31:0]        addr_wide,
    output logic [NUM_LANES-1:0]              ven_lanes,
    output logic [$clog2(VLMAX)-1:0]          elem_base,
    output logic                              busy,
    output logic                              done,
    output logic                              fault,
    output logic [$clog2(VLMAX)-1:0]          fault_idx
);

    localparam int EW  = $clog2(VLMAX);
    localparam int CW  = EW + 1;
    localparam int LW  = $clog2(NUM_LANES);
    localparam int LNW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_store;
    logic [1:0]         r_eew;
    logic [CW-1:0]      r_vl;
    logic               r_vm;
    logic [VLMAX-1:0]   r_vmask;
    logic [31:0]        r_beat_addr;
    // One bit wider than elem_base so the final advance past VLMAX cannot wrap.
    logic [CW-1:0]      r_elem;
    logic [EW-1:0]      r_fault_idx;

    logic [1:0]                    w_eew;
    logic [NUM_LANES-1:0][31:0]    w_addr;
    logic [NUM_LANES-1:0]          w_en;
    logic [NUM_LANES-1:0]          w_mis;
    logic [31:0]                   w_align_mask;
    logic [31:0]                   w_next_addr;
    logic [CW-1:0]                 w_next_elem;
    logic [LNW-1:0]                w_mis_lane;
    logic                          w_issue;
    logic                          w_any_mis;
    logic                          w_any_en;

    assign w_eew        = (eew == 2'b11) ? 2'b10 : eew;
    assign w_align_mask = (32'd1 << r_eew) - 32'd1;
    assign w_next_elem  = r_elem + CW'(NUM_LANES);

`ifdef RV32V_STRIDED_EN
    logic [31:0] r_es;
    assign w_next_addr = r_beat_addr + (r_es << LW);
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{stride, strided};
    assign w_next_addr  = r_beat_addr + (32'(NUM_LANES) << r_eew);
`endif

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [CW-1:0] w_idx;
        assign w_idx = r_elem + CW'(i);
`ifdef RV32V_STRIDED_EN
        assign w_addr[i] = r_beat_addr + r_es * 32'(i);
`else
        assign w_addr[i] = r_beat_addr + (32'(i) << r_eew);
`endif
        assign w_en[i]  = (w_idx < r_vl) && (w_idx < CW'(VLMAX)) &&
                          (r_vm || r_vmask[w_idx[EW-1:0]]);
        assign w_mis[i] = w_en[i] && ((w_addr[i] & w_align_mask) != 32'd0);
    end

    always_comb begin
        w_mis_lane = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (w_mis[i]) begin
                w_mis_lane = LNW'(i);
            end
        end
    end

    assign w_issue   = (r_state == S_ISSUE);
    assign w_any_mis = |w_mis;
    assign w_any_en  = |w_en;

    // Beat outputs are forced to zero outside ISSUE so idle state is all-zero.
    assign addr_wide = w_issue ? w_addr : '0;
    assign ven_lanes = w_issue ? w_en : '0;
    assign elem_base = w_issue ? r_elem[EW-1:0] : '0;
    assign wen       = w_issue && !w_any_mis && w_any_en && r_store;
    assign ren       = w_issue && !w_any_mis && w_any_en && !r_store;
    assign req_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign fault     = (r_state == S_FAULT);
    assign fault_idx = r_fault_idx;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state     <= S_IDLE;
            r_store     <= 1'b0;
            r_eew       <= 2'b00;
            r_vl        <= '0;
            r_vm        <= 1'b0;
            r_vmask     <= '0;
            r_beat_addr <= 32'd0;
            r_elem      <= '0;
            r_fault_idx <= '0;
`ifdef RV32V_STRIDED_EN
            r_es        <= 32'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_store     <= req_store;
                        r_eew       <= w_eew;
                        r_vl        <= vl;
                        r_vm        <= vm;
                        r_vmask     <= vmask;
                        r_beat_addr <= base;
                        r_elem      <= '0;
`ifdef RV32V_STRIDED_EN
                        r_es        <= strided ? stride : (32'd1 << w_eew);
`endif
                        r_state     <= (vl == '0) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_any_mis) begin
                        r_fault_idx <= r_elem[EW-1:0] + EW'(w_mis_lane);
                        r_state     <= S_FAULT;
                    end else if (!w_any_en || lsc_ready) begin
                        r_beat_addr <= w_next_addr;
                        r_elem      <= w_next_elem;
                        if (w_next_elem >= r_vl) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_FAULT: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv32v_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32v_addr_gen
// Purpose  : Directed self-checking bench for rv32v_addr_gen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32v_addr_gen;

    logic              CLK;
    logic              nRST;
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [31:0]       base;
    logic [31:0]       stride;
    logic              strided;
    logic [1:0]        eew;
    logic [5:0]        vl;
    logic              vm;
    logic [31:0]       vmask;
    logic              lsc_ready;
    logic              wen;
    logic              ren;
    logic [3:0][31:0]  addr_wide;
    logic [3:0]        ven_lanes;
    logic [4:0]        elem_base;
    logic              busy;
    logic              done;
    logic              fault;
    logic [4:0]        fault_idx;

    int n_pass  = 0;
    int n_total = 0;

    rv32v_addr_gen #(.NUM_LANES(4), .VLMAX(32)) dut (
        .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_ready(req_ready),
        .req_store(req_store), .base(base), .stride(stride), .strided(strided),
        .eew(eew), .vl(vl), .vm(vm), .vmask(vmask), .lsc_ready(lsc_ready),
        .wen(wen), .ren(ren), .addr_wide(addr_wide), .ven_lanes(ven_lanes),
        .elem_base(elem_base), .busy(busy), .done(done), .fault(fault),
        .fault_idx(fault_idx)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Presents one request for a single edge; on return the block has left IDLE.
    task automatic start(input logic st, input logic [31:0] b, input logic [31:0] s,
                         input logic sm, input logic [1:0] w, input logic [5:0] n,
                         input logic m, input logic [31:0] mk);
        req_store = st; base = b; stride = s; strided = sm; eew = w;
        vl = n; vm = m; vmask = mk; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    // Status vector: {req_ready, busy, wen, ren, done, fault}
    initial begin
        nRST = 1'b0; req_valid = 1'b0; req_store = 1'b0; base = '0; stride = '0;
        strided = 1'b0; eew = '0; vl = '0; vm = 1'b0; vmask = '0; lsc_ready = 1'b0;
        tick(); tick();
        chk("reset_status", {req_ready, busy, wen, ren, done, fault}, 6'b100000);
        chk("reset_addr", addr_wide, 128'd0);
        chk("reset_ven", ven_lanes, 4'b0000);
        chk("reset_idx", {elem_base, fault_idx}, 10'd0);
        nRST = 1'b1;
        tick();

        // Unit-stride 32-bit load, 8 elements, two full beats
        lsc_ready = 1'b1;
        start(1'b0, 32'h1000, 32'd0, 1'b0, 2'b10, 6'd8, 1'b1, 32'd0);
        chk("us_b0_addr", addr_wide, 128'h0000100C_00001008_00001004_00001000);
        chk("us_b0_ven", ven_lanes, 4'b1111);
        chk("us_b0_status", {req_ready, busy, wen, ren, done, fault}, 6'b010100);
        chk("us_b0_elem", elem_base, 5'd0);
        tick();
        chk("us_b1_addr", addr_wide, 128'h0000101C_00001018_00001014_00001010);
        chk("us_b1_ven", ven_lanes, 4'b1111);
        chk("us_b1_status", {req_ready, busy, wen, ren, done, fault}, 6'b010100);
        chk("us_b1_elem", elem_base, 5'd4);
        tick();
        chk("us_done", {req_ready, busy, wen, ren, done, fault}, 6'b010010);
        tick();
        chk("us_idle", {req_ready, busy, wen, ren, done, fault}, 6'b100000);

        // Tail and mask
        start(1'b0, 32'h1000, 32'd0, 1'b0, 2'b10, 6'd6, 1'b0, 32'h2D);
        chk("tm_b0_ven", ven_lanes, 4'b1101);
        chk("tm_b0_ren", ren, 1'b1);
        tick();
        chk("tm_b1_ven", ven_lanes, 4'b0010);
        chk("tm_b1_addr", addr_wide, 128'h0000101C_00001018_00001014_00001010);
        tick();
        chk("tm_done", done, 1'b1);
        tick();

        // Store with backpressure: beat must hold across the stall
        lsc_ready = 1'b0;
        start(1'b1, 32'h200, 32'hFFFF_FFF8, 1'b1, 2'b10, 6'd8, 1'b1, 32'd0);
        for (int k = 0; k < 3; k++) begin
`ifdef RV32V_STRIDED_EN
            chk("bp_stall_addr", addr_wide, 128'h000001E8_000001F0_000001F8_00000200);
`else
            chk("bp_stall_addr", addr_wide, 128'h0000020C_00000208_00000204_00000200);
`endif
            chk("bp_stall_status", {req_ready, busy, wen, ren, done, fault}, 6'b011000);
            chk("bp_stall_elem", elem_base, 5'd0);
            tick();
        end
        lsc_ready = 1'b1;
        tick();
`ifdef RV32V_STRIDED_EN
        chk("bp_b1_addr", addr_wide, 128'h000001C8_000001D0_000001D8_000001E0);
`else
        chk("bp_b1_addr", addr_wide, 128'h0000021C_00000218_00000214_00000210);
`endif
        chk("bp_b1_wen", {wen, ren}, 2'b10);
        tick();
        chk("bp_done", done, 1'b1);
        tick();

        // Misaligned 16-bit access at lane 0
        start(1'b0, 32'h101, 32'd0, 1'b0, 2'b01, 6'd4, 1'b1, 32'd0);
        chk("mis0_strobe", {wen, ren}, 2'b00);
        tick();
        chk("mis0_fault", {req_ready, busy, wen, ren, done, fault}, 6'b010001);
        chk("mis0_idx", fault_idx, 5'd0);
        tick();
        chk("mis0_idle", {req_ready, busy, wen, ren, done, fault}, 6'b100000);

        // Masked-off lanes 0,1 are not checked: lowest faulting element is 2
        start(1'b0, 32'h1002, 32'd0, 1'b0, 2'b10, 6'd4, 1'b0, 32'h0C);
        chk("mis2_strobe", {wen, ren}, 2'b00);
        tick();
        chk("mis2_fault", fault, 1'b1);
        chk("mis2_idx", fault_idx, 5'd2);
        tick();

        // Fully masked first beat advances without lsc_ready
        lsc_ready = 1'b0;
        start(1'b0, 32'h3000, 32'd0, 1'b0, 2'b10, 6'd8, 1'b0, 32'hF0);
        chk("fm_b0_ven", ven_lanes, 4'b0000);
        chk("fm_b0_strobe", {wen, ren}, 2'b00);
        tick();
        chk("fm_b1_elem", elem_base, 5'd4);
        chk("fm_b1_ven", ven_lanes, 4'b1111);
        chk("fm_b1_ren", ren, 1'b1);
        lsc_ready = 1'b1;
        tick();
        chk("fm_done", done, 1'b1);
        tick();

        // vl = 0 goes straight to DONE
        start(1'b1, 32'h4000, 32'd0, 1'b0, 2'b10, 6'd0, 1'b1, 32'd0);
        chk("vl0_done", {req_ready, busy, wen, ren, done, fault}, 6'b010010);
        tick();
        chk("vl0_idle", {req_ready, busy, wen, ren, done, fault}, 6'b100000);

        // Reset during the second beat
        start(1'b0, 32'h5000, 32'd0, 1'b0, 2'b10, 6'd8, 1'b1, 32'd0);
        tick();
        chk("rst_b1_elem", elem_base, 5'd4);
        nRST = 1'b0;
        tick();
        chk("rst_status", {req_ready, busy, wen, ren, done, fault}, 6'b100000);
        chk("rst_addr", addr_wide, 128'd0);
        nRST = 1'b1;
        tick();
        chk("rst_no_done", {req_ready, busy, done}, 3'b100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
